// File: rtl/instr_fetch_pkg.sv
// Shared encodings and constants for the instruction fetch controller.
package instr_fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_RUN  = 2'b10,
        ST_HALT = 2'b11
    } fetch_state_t;

    localparam int          WORD_BYTES = 4;
    localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/instr_fetch_ctrl_if.sv
// Loader, instruction-memory and decode-side signals of the fetch controller.
interface instr_fetch_ctrl_if;
    logic        start_i;
    logic        ld_valid_i;
    logic [31:0] ld_data_i;
    logic        ld_last_i;
    logic        ld_ready_o;
    logic [31:0] mem_addr_o;
    logic        mem_we_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_addr_i;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic        instr_valid_o;
    logic [1:0]  state_o;

    modport master (
        input  start_i, ld_valid_i, ld_data_i, ld_last_i, mem_rdata_i,
               stall_i, redirect_i, redirect_addr_i,
        output ld_ready_o, mem_addr_o, mem_we_o, mem_wdata_o,
               instr_o, pc_o, instr_valid_o, state_o
    );

    modport slave (
        output start_i, ld_valid_i, ld_data_i, ld_last_i, mem_rdata_i,
               stall_i, redirect_i, redirect_addr_i,
        input  ld_ready_o, mem_addr_o, mem_we_o, mem_wdata_o,
               instr_o, pc_o, instr_valid_o, state_o
    );
endinterface

// File: rtl/imem_load_seq.sv
// Boot-loader write path: word pointer plus ready/we/addr/wdata generation.
module imem_load_seq
    import instr_fetch_pkg::*;
#(
    parameter int MEM_WORDS = 32
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        enable,
    input  logic        ld_valid,
    input  logic        ld_last,
    input  logic [31:0] ld_data,
    output logic        ld_ready,
    output logic        ld_we,
    output logic        ld_done,
    output logic [31:0] ld_addr,
    output logic [31:0] ld_wdata
);

    localparam int PTR_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

    logic [PTR_W-1:0] ld_ptr;

    assign ld_ready = enable;
    assign ld_we    = ld_valid & enable;
    assign ld_done  = ld_we & ld_last;
    assign ld_addr  = 32'(ld_ptr) * WORD_BYTES;
    assign ld_wdata = ld_data;

    // Pointer wraps at the memory depth; the final word rewinds it for the next load.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            ld_ptr <= '0;
        end else if (ld_we) begin
            if (ld_last || (ld_ptr == PTR_W'(MEM_WORDS - 1)))
                ld_ptr <= '0;
            else
                ld_ptr <= ld_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: PC sequencing, fetch register and loader port sharing.
// Optional build macro HALT_ON_ZERO_EN: a fetched zero word ends the program.
//
//   state   | meaning
//   --------+----------------------------------------------
//   IDLE    | port owned by loader, waiting for words/start
//   LOAD    | mid-program load, start ignored
//   RUN     | fetching one word per cycle from pc
//   HALT    | fetch ran off the end, waiting for start
module instr_fetch_ctrl
    import instr_fetch_pkg::*;
#(
    parameter int          MEM_WORDS = 32,
    parameter logic [31:0] RESET_PC  = 32'h0
) (
    input  logic               clk_i,
    input  logic               rst_i,
    instr_fetch_ctrl_if.master bus
);

    localparam logic [31:0] PC_LIMIT = 32'(MEM_WORDS * WORD_BYTES);

    fetch_state_t state, state_nx;
    logic [31:0]  pc, pc_nx;
    logic [31:0]  instr_q, instr_nx;
    logic [31:0]  pc_q, pc_q_nx;
    logic         valid_q, valid_nx;

    logic         ld_enable, ld_we, ld_done, ld_ready;
    logic [31:0]  ld_addr, ld_wdata;

    assign ld_enable = (state == ST_IDLE) || (state == ST_LOAD);

    imem_load_seq #(.MEM_WORDS(MEM_WORDS)) u_load (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .enable   (ld_enable),
        .ld_valid (bus.ld_valid_i),
        .ld_last  (bus.ld_last_i),
        .ld_data  (bus.ld_data_i),
        .ld_ready (ld_ready),
        .ld_we    (ld_we),
        .ld_done  (ld_done),
        .ld_addr  (ld_addr),
        .ld_wdata (ld_wdata)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state   <= ST_IDLE;
            pc      <= RESET_PC;
            instr_q <= '0;
            pc_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            state   <= state_nx;
            pc      <= pc_nx;
            instr_q <= instr_nx;
            pc_q    <= pc_q_nx;
            valid_q <= valid_nx;
        end
    end

    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        instr_nx = instr_q;
        pc_q_nx  = pc_q;
        valid_nx = valid_q;
        unique case (state)
            ST_IDLE: begin
                if (ld_we) begin
                    if (!bus.ld_last_i) state_nx = ST_LOAD;
                end else if (bus.start_i) begin
                    state_nx = ST_RUN;
                    pc_nx    = RESET_PC;
                end
            end
            ST_LOAD: begin
                if (ld_done) state_nx = ST_IDLE;
            end
            ST_RUN: begin
                // Redirect beats both the bounds check and back-pressure.
                if (bus.redirect_i) begin
                    pc_nx    = bus.redirect_addr_i & ALIGN_MASK;
                    valid_nx = 1'b0;
                end else if (pc >= PC_LIMIT) begin
                    state_nx = ST_HALT;
                    valid_nx = 1'b0;
                end else if (bus.stall_i) begin
                    valid_nx = valid_q;
`ifdef HALT_ON_ZERO_EN
                end else if (bus.mem_rdata_i == 32'h0) begin
                    state_nx = ST_HALT;
                    valid_nx = 1'b0;
`endif
                end else begin
                    instr_nx = bus.mem_rdata_i;
                    pc_q_nx  = pc;
                    valid_nx = 1'b1;
                    pc_nx    = pc + 32'(WORD_BYTES);
                end
            end
            ST_HALT: begin
                valid_nx = 1'b0;
                if (bus.start_i) begin
                    state_nx = ST_RUN;
                    pc_nx    = RESET_PC;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    assign bus.ld_ready_o    = ld_ready;
    assign bus.mem_we_o      = ld_we;
    assign bus.mem_addr_o    = ld_we ? ld_addr : pc;
    assign bus.mem_wdata_o   = ld_wdata;
    assign bus.instr_o       = instr_q;
    assign bus.pc_o          = pc_q;
    assign bus.instr_valid_o = valid_q;
    assign bus.state_o       = state;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed bench for instr_fetch_ctrl with a behavioural 32-word instruction memory.
module tb_instr_fetch_ctrl;

    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    logic [31:0] mem [0:31] = '{default: 32'h0};

    instr_fetch_ctrl_if bus();

    instr_fetch_ctrl #(.MEM_WORDS(32), .RESET_PC(32'h0)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.mem_rdata_i = (bus.mem_addr_o < 32'd128) ? mem[bus.mem_addr_o[6:2]] : 32'h0;

    always @(posedge clk) begin
        if (bus.mem_we_o) mem[bus.mem_addr_o[6:2]] <= bus.mem_wdata_o;
    end

    localparam logic [31:0] W0 = 32'hA000_0011;
    localparam logic [31:0] W1 = 32'hB000_0022;
    localparam logic [31:0] W2 = 32'hC000_0033;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    task automatic load_word(input logic [31:0] data, input logic last);
        bus.ld_valid_i = 1'b1;
        bus.ld_data_i  = data;
        bus.ld_last_i  = last;
        tick();
        bus.ld_valid_i = 1'b0;
        bus.ld_last_i  = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tick();
        checks++; if (bus.state_o !== 2'b00) begin failures++; $display("FAIL reset_state got=%0h exp=0", bus.state_o); end
        checks++; if (bus.instr_valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", bus.instr_valid_o); end
        checks++; if (bus.instr_o !== 32'h0) begin failures++; $display("FAIL reset_instr got=%0h exp=0", bus.instr_o); end
        checks++; if (bus.pc_o !== 32'h0) begin failures++; $display("FAIL reset_pc got=%0h exp=0", bus.pc_o); end
        checks++; if (bus.ld_ready_o !== 1'b1) begin failures++; $display("FAIL reset_ready got=%0b exp=1", bus.ld_ready_o); end
        checks++; if (bus.mem_we_o !== 1'b0 || bus.mem_addr_o !== 32'h0) begin failures++; $display("FAIL reset_mem we=%0b addr=%0h exp we=0 addr=0", bus.mem_we_o, bus.mem_addr_o); end
    endtask

    task automatic test_load();
        logic [31:0] words [3] = '{W0, W1, W2};
        for (int i = 0; i < 3; i++) begin
            bus.ld_valid_i = 1'b1;
            bus.ld_data_i  = words[i];
            bus.ld_last_i  = (i == 2);
            bus.start_i    = (i == 1);
            #1;
            checks++; if (bus.mem_we_o !== 1'b1 || bus.mem_addr_o !== 32'(i * 4) || bus.mem_wdata_o !== words[i])
                begin failures++; $display("FAIL load_write%0d we=%0b addr=%0h data=%0h exp we=1 addr=%0h data=%0h", i, bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o, i * 4, words[i]); end
            tick();
            checks++; if (bus.state_o !== ((i == 2) ? 2'b00 : 2'b01)) begin failures++; $display("FAIL load_state%0d got=%0h exp=%0h", i, bus.state_o, (i == 2) ? 0 : 1); end
        end
        bus.ld_valid_i = 1'b0;
        bus.ld_last_i  = 1'b0;
        bus.start_i    = 1'b0;
        checks++; if (mem[2] !== W2) begin failures++; $display("FAIL load_mem2 got=%0h exp=%0h", mem[2], W2); end
    endtask

    task automatic test_fetch();
        logic [31:0] words [3] = '{W0, W1, W2};
        bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        checks++; if (bus.state_o !== 2'b10 || bus.instr_valid_o !== 1'b0) begin failures++; $display("FAIL start_run state=%0h valid=%0b exp state=2 valid=0", bus.state_o, bus.instr_valid_o); end
        checks++; if (bus.ld_ready_o !== 1'b0 || bus.mem_addr_o !== 32'h0) begin failures++; $display("FAIL start_port ready=%0b addr=%0h exp ready=0 addr=0", bus.ld_ready_o, bus.mem_addr_o); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (bus.instr_valid_o !== 1'b1 || bus.instr_o !== words[i] || bus.pc_o !== 32'(i * 4))
                begin failures++; $display("FAIL fetch%0d valid=%0b instr=%0h pc=%0h exp valid=1 instr=%0h pc=%0h", i, bus.instr_valid_o, bus.instr_o, bus.pc_o, words[i], i * 4); end
        end
    endtask

    task automatic test_redirect();
        bus.redirect_i      = 1'b1;
        bus.redirect_addr_i = 32'h0000_0008;
        tick();
        checks++; if (bus.instr_valid_o !== 1'b0 || bus.pc_o !== 32'h8 || bus.instr_o !== W2 || bus.mem_addr_o !== 32'h8)
            begin failures++; $display("FAIL redir_to8 valid=%0b pc=%0h instr=%0h addr=%0h exp 0/8/%0h/8", bus.instr_valid_o, bus.pc_o, bus.instr_o, bus.mem_addr_o, W2); end
        bus.redirect_addr_i = 32'h0000_0006;
        bus.stall_i         = 1'b1;
        tick();
        checks++; if (bus.instr_valid_o !== 1'b0 || bus.pc_o !== 32'h8 || bus.mem_addr_o !== 32'h4)
            begin failures++; $display("FAIL redir_stall valid=%0b pc=%0h addr=%0h exp 0/8/4", bus.instr_valid_o, bus.pc_o, bus.mem_addr_o); end
        bus.redirect_i = 1'b0;
        bus.stall_i    = 1'b0;
        tick();
        checks++; if (bus.instr_valid_o !== 1'b1 || bus.pc_o !== 32'h4 || bus.instr_o !== W1)
            begin failures++; $display("FAIL redir_issue valid=%0b pc=%0h instr=%0h exp 1/4/%0h", bus.instr_valid_o, bus.pc_o, bus.instr_o, W1); end
    endtask

    task automatic test_stall();
        bus.stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (bus.instr_valid_o !== 1'b1 || bus.pc_o !== 32'h4 || bus.instr_o !== W1 || bus.mem_addr_o !== 32'h8)
                begin failures++; $display("FAIL stall%0d valid=%0b pc=%0h instr=%0h addr=%0h exp 1/4/%0h/8", i, bus.instr_valid_o, bus.pc_o, bus.instr_o, bus.mem_addr_o, W1); end
        end
        bus.stall_i = 1'b0;
        tick();
        checks++; if (bus.instr_valid_o !== 1'b1 || bus.pc_o !== 32'h8 || bus.instr_o !== W2)
            begin failures++; $display("FAIL stall_release valid=%0b pc=%0h instr=%0h exp 1/8/%0h", bus.instr_valid_o, bus.pc_o, bus.instr_o, W2); end
    endtask

    task automatic test_zero_word();
        do_reset();
        checks++; if (bus.state_o !== 2'b00 || bus.instr_valid_o !== 1'b0) begin failures++; $display("FAIL runreset state=%0h valid=%0b exp 0/0", bus.state_o, bus.instr_valid_o); end
        load_word(32'h1111_0001, 1'b0);
        load_word(32'h2222_0002, 1'b0);
        load_word(32'h0000_0000, 1'b1);
        bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        tick();
        checks++; if (bus.instr_valid_o !== 1'b1 || bus.pc_o !== 32'h0 || bus.instr_o !== 32'h1111_0001)
            begin failures++; $display("FAIL zero_w0 valid=%0b pc=%0h instr=%0h exp 1/0/11110001", bus.instr_valid_o, bus.pc_o, bus.instr_o); end
        tick();
        checks++; if (bus.instr_valid_o !== 1'b1 || bus.pc_o !== 32'h4 || bus.instr_o !== 32'h2222_0002)
            begin failures++; $display("FAIL zero_w1 valid=%0b pc=%0h instr=%0h exp 1/4/22220002", bus.instr_valid_o, bus.pc_o, bus.instr_o); end
        tick();
`ifdef HALT_ON_ZERO_EN
        checks++; if (bus.state_o !== 2'b11 || bus.instr_valid_o !== 1'b0)
            begin failures++; $display("FAIL zero_halt state=%0h valid=%0b exp 3/0", bus.state_o, bus.instr_valid_o); end
`else
        checks++; if (bus.state_o !== 2'b10 || bus.instr_valid_o !== 1'b1 || bus.pc_o !== 32'h8 || bus.instr_o !== 32'h0)
            begin failures++; $display("FAIL zero_issue state=%0h valid=%0b pc=%0h instr=%0h exp 2/1/8/0", bus.state_o, bus.instr_valid_o, bus.pc_o, bus.instr_o); end
`endif
    endtask

    task automatic test_bounds();
        do_reset();
        for (int i = 0; i < 32; i++) load_word(32'h5000_0000 + 32'(i), (i == 31));
        bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        for (int i = 0; i < 32; i++) begin
            tick();
            checks++; if (bus.instr_valid_o !== 1'b1 || bus.pc_o !== 32'(i * 4) || bus.instr_o !== 32'h5000_0000 + 32'(i))
                begin failures++; $display("FAIL bound_fetch%0d valid=%0b pc=%0h instr=%0h exp 1/%0h/%0h", i, bus.instr_valid_o, bus.pc_o, bus.instr_o, i * 4, 32'h5000_0000 + 32'(i)); end
        end
        tick();
        checks++; if (bus.state_o !== 2'b11 || bus.instr_valid_o !== 1'b0 || bus.ld_ready_o !== 1'b0)
            begin failures++; $display("FAIL bound_halt state=%0h valid=%0b ready=%0b exp 3/0/0", bus.state_o, bus.instr_valid_o, bus.ld_ready_o); end
        bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        checks++; if (bus.state_o !== 2'b10 || bus.mem_addr_o !== 32'h0)
            begin failures++; $display("FAIL restart state=%0h addr=%0h exp 2/0", bus.state_o, bus.mem_addr_o); end
        tick();
        checks++; if (bus.instr_valid_o !== 1'b1 || bus.pc_o !== 32'h0 || bus.instr_o !== 32'h5000_0000)
            begin failures++; $display("FAIL refetch valid=%0b pc=%0h instr=%0h exp 1/0/50000000", bus.instr_valid_o, bus.pc_o, bus.instr_o); end
    endtask

    task automatic test_reset_mid_load();
        do_reset();
        load_word(32'h7777_0000, 1'b0);
        load_word(32'h7777_0001, 1'b0);
        checks++; if (bus.state_o !== 2'b01) begin failures++; $display("FAIL midload_state got=%0h exp=1", bus.state_o); end
        do_reset();
        checks++; if (bus.state_o !== 2'b00) begin failures++; $display("FAIL midload_reset got=%0h exp=0", bus.state_o); end
        bus.ld_valid_i = 1'b1;
        bus.ld_data_i  = 32'h9999_ABCD;
        bus.ld_last_i  = 1'b1;
        #1;
        checks++; if (bus.mem_we_o !== 1'b1 || bus.mem_addr_o !== 32'h0)
            begin failures++; $display("FAIL reload_addr we=%0b addr=%0h exp we=1 addr=0", bus.mem_we_o, bus.mem_addr_o); end
        tick();
        bus.ld_valid_i = 1'b0;
        bus.ld_last_i  = 1'b0;
        checks++; if (bus.state_o !== 2'b00 || mem[0] !== 32'h9999_ABCD)
            begin failures++; $display("FAIL reload_done state=%0h mem0=%0h exp 0/9999abcd", bus.state_o, mem[0]); end
    endtask

    initial begin
        rst                 = 1'b0;
        bus.start_i         = 1'b0;
        bus.ld_valid_i      = 1'b0;
        bus.ld_data_i       = 32'h0;
        bus.ld_last_i       = 1'b0;
        bus.stall_i         = 1'b0;
        bus.redirect_i      = 1'b0;
        bus.redirect_addr_i = 32'h0;
        test_reset();
        test_load();
        test_fetch();
        test_redirect();
        test_stall();
        test_zero_word();
        test_bounds();
        test_reset_mid_load();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
